// File: rtl/memmap_pkg.sv
// memmap_pkg: shared constants and types for the memory-map block.
//   - Region base/limit addresses for the CPU address decode
//   - External SRAM address width
//   - External-cycle FSM state encoding and decoded region enum
//   - Helper function for inclusive address-range tests
package memmap_pkg;

  localparam int EXT_AW = 18;

  localparam logic [15:0] RAMPAGE_BASE  = 16'h8000;
  localparam logic [15:0] RAMPAGE_LIMIT = 16'hBFFF;
  localparam logic [15:0] BRAM_BASE     = 16'hE000;
  localparam logic [15:0] BRAM_LIMIT    = 16'hEFFF;
  localparam logic [15:0] SYSBOOT_BASE  = 16'hF000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } memmap_state_t;

  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_BROM = 2'd1,
    RGN_BRAM = 2'd2,
    RGN_EXT  = 2'd3
  } memmap_region_t;

  // Inclusive range test on a 16-bit CPU address.
  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/memmap_decode.sv
// memmap_decode: purely combinational CPU address decode.
// Inputs : cpu_addr, cpu_rw, cpu_vma, page {R,PPP}, lock and disable bits.
// Outputs: region (none/ROM/RAM/external), ext_addr (18-bit SRAM address),
//          locked (write into a write-protected external area).
// First match wins: sysboot, built-in RAM, RAM page window, linear external.
module memmap_decode
  import memmap_pkg::*;
(
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rw,
  input  logic              cpu_vma,
  input  logic [3:0]        page,
  input  logic              rampage_lock,
  input  logic              sysboot_lock,
  input  logic              bram_disable,
  input  logic              brom_disable,
  output memmap_region_t    region,
  output logic [EXT_AW-1:0] ext_addr,
  output logic              locked
);

  // Region priority decode and physical address formation.
  always_comb begin
    region   = RGN_NONE;
    ext_addr = {2'b00, cpu_addr};
    locked   = 1'b0;
    if (!cpu_vma) begin
      region = RGN_NONE;
    end else if (cpu_addr >= SYSBOOT_BASE) begin
      if (!brom_disable) begin
        // ROM writes are dropped silently; they are never a violation.
        region = RGN_BROM;
      end else begin
        region = RGN_EXT;
        locked = sysboot_lock & ~cpu_rw;
      end
    end else if (in_range(cpu_addr, BRAM_BASE, BRAM_LIMIT) && !bram_disable) begin
      region = RGN_BRAM;
    end else if (in_range(cpu_addr, RAMPAGE_BASE, RAMPAGE_LIMIT) && page[3]) begin
      region   = RGN_EXT;
      ext_addr = {1'b1, page[2:0], cpu_addr[13:0]};
      locked   = rampage_lock & ~cpu_rw;
    end else begin
      region = RGN_EXT;
    end
  end

endmodule

// File: rtl/memmap.sv
// memmap: address translation and external-SRAM sequencer.
// Ports:
//   clk, rst (async active-low)
//   cpu_addr/cpu_rw/cpu_vma : CPU bus cycle;  cpu_ready : 0 stalls the CPU
//   page, rampage_lock, sysboot_lock, bram_disable, brom_disable : page/lock bits
//   brom_cs, bram_cs        : built-in ROM/RAM selects (combinational)
//   ext_addr, ext_ce_n/oe_n/we_n : registered SRAM address and strobes
//   fault, fault_addr, fault_clr : sticky write-violation log
// External cycle: IDLE -> ACCESS (max(WAIT_STATES,1) cycles) -> HOLD (1) -> IDLE.
module memmap
  import memmap_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_rw,
  input  logic              cpu_vma,
  output logic              cpu_ready,
  input  logic [3:0]        page,
  input  logic              rampage_lock,
  input  logic              sysboot_lock,
  input  logic              bram_disable,
  input  logic              brom_disable,
  output logic              brom_cs,
  output logic              bram_cs,
  output logic [EXT_AW-1:0] ext_addr,
  output logic              ext_ce_n,
  output logic              ext_oe_n,
  output logic              ext_we_n,
  output logic              fault,
  output logic [15:0]       fault_addr,
  input  logic              fault_clr
);

  localparam int WS_EFF = (WAIT_STATES < 1) ? 1 : WAIT_STATES;
  localparam int CNT_W  = (WS_EFF > 1) ? $clog2(WS_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WS_EFF - 1);

  memmap_region_t    region;
  logic [EXT_AW-1:0] dec_addr;
  logic              dec_locked;

  memmap_state_t     state_r, state_next;
  logic [CNT_W-1:0]  cnt_r, cnt_next;
  logic              rw_r, rw_next;
  logic              accept, violation;

  memmap_decode u_decode (
    .cpu_addr     (cpu_addr),
    .cpu_rw       (cpu_rw),
    .cpu_vma      (cpu_vma),
    .page         (page),
    .rampage_lock (rampage_lock),
    .sysboot_lock (sysboot_lock),
    .bram_disable (bram_disable),
    .brom_disable (brom_disable),
    .region       (region),
    .ext_addr     (dec_addr),
    .locked       (dec_locked)
  );

  assign brom_cs = (region == RGN_BROM);
  assign bram_cs = (region == RGN_BRAM);

  // Requests are only looked at in IDLE; vma is ignored mid-access.
  assign accept    = (state_r == ST_IDLE) && (region == RGN_EXT) && !dec_locked;
  assign violation = (state_r == ST_IDLE) && (region == RGN_EXT) && dec_locked;

  // Next-state and wait-state counter logic.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    rw_next    = rw_r;
    case (state_r)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ACCESS;
          cnt_next   = CNT_LOAD;
          rw_next    = cpu_rw;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == '0) begin
          state_next = ST_HOLD;
        end else begin
          cnt_next = cnt_r - 1'b1;
        end
      end
      ST_HOLD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state, latched access attributes and registered strobes/ready.
  // Strobes are computed from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      rw_r      <= 1'b1;
      ext_addr  <= '0;
      ext_ce_n  <= 1'b1;
      ext_oe_n  <= 1'b1;
      ext_we_n  <= 1'b1;
      cpu_ready <= 1'b1;
    end else begin
      state_r   <= state_next;
      cnt_r     <= cnt_next;
      rw_r      <= rw_next;
      if (accept) begin
        ext_addr <= dec_addr;
      end
      ext_ce_n  <= (state_next == ST_IDLE);
      ext_oe_n  <= !((state_next == ST_ACCESS) && rw_next);
      ext_we_n  <= !((state_next == ST_ACCESS) && !rw_next);
      cpu_ready <= (state_next != ST_ACCESS);
    end
  end

  // Sticky fault log; a new violation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault      <= 1'b0;
      fault_addr <= 16'h0000;
    end else if (violation && (!fault || fault_clr)) begin
      fault      <= 1'b1;
      fault_addr <= cpu_addr;
    end else if (fault_clr) begin
      fault      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memmap.sv
// tb_memmap: self-checking bench for memmap (WAIT_STATES = 2).
// A vector table covers the region decode; hand-written sequences cover
// the wait-state timing, page changes in flight, fault logging and reset.
module tb_memmap;
  import memmap_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       cpu_addr = 16'h0000;
  logic              cpu_rw = 1'b1;
  logic              cpu_vma = 1'b0;
  logic              cpu_ready;
  logic [3:0]        page = 4'h0;
  logic              rampage_lock = 1'b0;
  logic              sysboot_lock = 1'b0;
  logic              bram_disable = 1'b0;
  logic              brom_disable = 1'b0;
  logic              brom_cs, bram_cs;
  logic [EXT_AW-1:0] ext_addr;
  logic              ext_ce_n, ext_oe_n, ext_we_n;
  logic              fault;
  logic [15:0]       fault_addr;
  logic              fault_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memmap #(.WAIT_STATES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_rw       (cpu_rw),
    .cpu_vma      (cpu_vma),
    .cpu_ready    (cpu_ready),
    .page         (page),
    .rampage_lock (rampage_lock),
    .sysboot_lock (sysboot_lock),
    .bram_disable (bram_disable),
    .brom_disable (brom_disable),
    .brom_cs      (brom_cs),
    .bram_cs      (bram_cs),
    .ext_addr     (ext_addr),
    .ext_ce_n     (ext_ce_n),
    .ext_oe_n     (ext_oe_n),
    .ext_we_n     (ext_we_n),
    .fault        (fault),
    .fault_addr   (fault_addr),
    .fault_clr    (fault_clr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic        vma;
    logic [3:0]  page;
    logic        brom_dis;
    logic        bram_dis;
    logic        sb_lock;
    logic        exp_rom;
    logic        exp_ram;
    logic        exp_ext;
    logic [17:0] exp_addr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    //          addr      rw    vma   page   bromd bramd sblk  rom   ram   ext   ext_addr
    vecs[0]  = '{16'hFFFE, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00000};
    vecs[1]  = '{16'hF000, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h00000};
    vecs[2]  = '{16'hE123, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'h00000};
    vecs[3]  = '{16'hE123, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h0E123};
    // {1, page[2:0]=101, 0x9234[13:0]=0x1234} = 0x34000 + 0x1234
    vecs[4]  = '{16'h9234, 1'b1, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'h35234};
    vecs[5]  = '{16'h9234, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'h09234};
    vecs[6]  = '{16'hC000, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'h0C000};
    vecs[7]  = '{16'hF800, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'h0F800};
    vecs[8]  = '{16'hE000, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00000};
    vecs[9]  = '{16'hBFFF, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'h23FFF};
    vecs[10] = '{16'h7FFF, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'h07FFF};
    vecs[11] = '{16'h8000, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 18'h3C000};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", cpu_ready, 1);
    check("rst_ce_n", ext_ce_n, 1);
    check("rst_fault", fault, 0);
    check("rst_ext_addr", ext_addr, 0);
    check("rst_fault_addr", fault_addr, 0);
    rst = 1'b1;

    // Table-driven decode
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cpu_addr     = vecs[i].addr;
      cpu_rw       = vecs[i].rw;
      cpu_vma      = vecs[i].vma;
      page         = vecs[i].page;
      brom_disable = vecs[i].brom_dis;
      bram_disable = vecs[i].bram_dis;
      sysboot_lock = vecs[i].sb_lock;
      #1;
      check($sformatf("v%0d_brom_cs", i), brom_cs, vecs[i].exp_rom);
      check($sformatf("v%0d_bram_cs", i), bram_cs, vecs[i].exp_ram);
      @(negedge clk);
      cpu_vma = 1'b0;
      if (vecs[i].exp_ext) begin
        check($sformatf("v%0d_ext_addr", i), ext_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_ce_n", i), ext_ce_n, 0);
        check($sformatf("v%0d_oe_n", i), ext_oe_n, !vecs[i].rw);
        check($sformatf("v%0d_we_n", i), ext_we_n, vecs[i].rw);
        check($sformatf("v%0d_ready", i), cpu_ready, 0);
      end else begin
        check($sformatf("v%0d_ce_n", i), ext_ce_n, 1);
        check($sformatf("v%0d_ready", i), cpu_ready, 1);
      end
      check($sformatf("v%0d_fault", i), fault, 0);
      repeat (4) @(negedge clk);
    end
    brom_disable = 1'b0;
    bram_disable = 1'b0;
    sysboot_lock = 1'b0;

    // Wait-state timing: page 1101, read $9234
    @(negedge clk);
    page = 4'hD; cpu_addr = 16'h9234; cpu_rw = 1'b1; cpu_vma = 1'b1;
    @(negedge clk);
    cpu_vma = 1'b0;
    check("ws_c1_ready", cpu_ready, 0);
    check("ws_c1_oe_n", ext_oe_n, 0);
    check("ws_c1_addr", ext_addr, 18'h35234);
    @(negedge clk);
    check("ws_c2_ready", cpu_ready, 0);
    check("ws_c2_ce_n", ext_ce_n, 0);
    check("ws_c2_oe_n", ext_oe_n, 0);
    @(negedge clk);
    check("ws_hold_ready", cpu_ready, 1);
    check("ws_hold_ce_n", ext_ce_n, 0);
    check("ws_hold_oe_n", ext_oe_n, 1);
    @(negedge clk);
    check("ws_idle_ce_n", ext_ce_n, 1);
    check("ws_idle_ready", cpu_ready, 1);

    // Page change in flight; locked write during ACCESS/HOLD is ignored
    @(negedge clk);
    page = 4'h9; cpu_addr = 16'h8004; cpu_rw = 1'b1; cpu_vma = 1'b1;
    @(negedge clk);
    page = 4'hA; rampage_lock = 1'b1; cpu_addr = 16'h8010; cpu_rw = 1'b0;
    check("pg_c1_addr", ext_addr, 18'h24004);
    @(negedge clk);
    check("pg_c2_addr", ext_addr, 18'h24004);
    @(negedge clk);
    check("pg_hold_addr", ext_addr, 18'h24004);
    check("pg_hold_we_n", ext_we_n, 1);
    cpu_vma = 1'b0;
    @(negedge clk);
    check("pg_idle_ce_n", ext_ce_n, 1);
    check("pg_no_fault", fault, 0);

    // Locked rampage write: fault logged, no strobes, no stall
    page = 4'h8; cpu_addr = 16'h8010; cpu_rw = 1'b0; cpu_vma = 1'b1;
    #1;
    check("lk_ready_comb", cpu_ready, 1);
    @(negedge clk);
    check("lk_ce_n", ext_ce_n, 1);
    check("lk_we_n", ext_we_n, 1);
    check("lk_ready", cpu_ready, 1);
    check("lk_fault", fault, 1);
    check("lk_fault_addr", fault_addr, 16'h8010);
    cpu_addr = 16'hA000;
    @(negedge clk);
    check("lk2_fault_addr", fault_addr, 16'h8010);
    cpu_vma = 1'b0;

    // Clear only: fault drops, address kept
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_fault_addr", fault_addr, 16'h8010);

    // ROM read with ROM enabled, then locked sysboot write with ROM disabled
    cpu_addr = 16'hFFFE; cpu_rw = 1'b1; cpu_vma = 1'b1;
    #1;
    check("rom_cs", brom_cs, 1);
    @(negedge clk);
    check("rom_ce_n", ext_ce_n, 1);
    brom_disable = 1'b1; sysboot_lock = 1'b1; cpu_addr = 16'hF000; cpu_rw = 1'b0;
    #1;
    check("sb_rom_cs", brom_cs, 0);
    @(negedge clk);
    check("sb_fault", fault, 1);
    check("sb_fault_addr", fault_addr, 16'hF000);
    check("sb_ce_n", ext_ce_n, 1);

    // Clear and violation on the same edge: violation wins
    cpu_addr = 16'hB000; fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0; cpu_vma = 1'b0;
    check("cv_fault", fault, 1);
    check("cv_fault_addr", fault_addr, 16'hB000);

    // Async reset in the middle of ACCESS
    rampage_lock = 1'b0; sysboot_lock = 1'b0; brom_disable = 1'b0;
    page = 4'h0; cpu_addr = 16'h1234; cpu_rw = 1'b1; cpu_vma = 1'b1;
    @(negedge clk);
    cpu_vma = 1'b0;
    check("ar_pre_ce_n", ext_ce_n, 0);
    #2;
    rst = 1'b0;
    #1;
    check("ar_ce_n", ext_ce_n, 1);
    check("ar_oe_n", ext_oe_n, 1);
    check("ar_ready", cpu_ready, 1);
    check("ar_fault", fault, 0);
    check("ar_ext_addr", ext_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_after_ce_n", ext_ce_n, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
